difftest_step_batcher: RTL



---
 rtl/difftest_step_batcher.sv | 87 ++++++++
 1 files changed

// File: rtl/difftest_step_batcher.sv
// Merges per-cycle difftest commit counts into batches for the host-side checker,
// stamping each batch with the free-running cycle count at which it was formed.
module difftest_step_batcher #(
  parameter int STEP_WIDTH  = 8,
  parameter int BATCH_WIDTH = 16,
  parameter int THRESHOLD   = 64,
  parameter int TIMEOUT     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [STEP_WIDTH-1:0]  in_step,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BATCH_WIDTH-1:0] out_step,
  output logic [63:0]            out_cycle,
  output logic                   pending,
  output logic                   overflow
);
  localparam int IDLE_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [BATCH_WIDTH-1:0] ACC_MAX   = '1;
  localparam logic [BATCH_WIDTH-1:0] THRESH_V  = BATCH_WIDTH'(THRESHOLD);
  localparam logic [IDLE_WIDTH-1:0]  TIMEOUT_V = IDLE_WIDTH'(TIMEOUT);
  localparam logic [IDLE_WIDTH-1:0]  IDLE_ONE  = IDLE_WIDTH'(1);

  logic [BATCH_WIDTH-1:0] acc;
  logic [IDLE_WIDTH-1:0]  idle_cnt;
  logic [63:0]            cyc;

  logic                   acc_nonzero;
  logic                   trigger;
  logic                   slot_free;
  logic                   load;
  logic                   clamp;
  logic [BATCH_WIDTH-1:0] step_ext;
  logic [BATCH_WIDTH:0]   sum;

  // Handshake: a batch transfers on any edge where out_valid && out_ready; while
  // out_valid is high and out_ready low the slot (step and cycle stamp) is frozen.
  // The slot counts as free when empty or draining, so drain and reload share an edge.
  always_comb begin
    step_ext    = BATCH_WIDTH'(in_step);
    acc_nonzero = (acc != '0);
    trigger     = acc_nonzero && ((acc >= THRESH_V) || (idle_cnt == TIMEOUT_V) || flush);
    slot_free   = !out_valid || out_ready;
    load        = trigger && slot_free;
    sum         = {1'b0, acc} + {1'b0, step_ext};
    clamp       = sum[BATCH_WIDTH];
  end

  assign pending = acc_nonzero || out_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc       <= '0;
      idle_cnt  <= '0;
      cyc       <= '0;
      out_valid <= 1'b0;
      out_step  <= '0;
      out_cycle <= '0;
      overflow  <= 1'b0;
    end else begin
      cyc <= cyc + 64'd1;
      if (load) begin
        out_valid <= 1'b1;
        out_step  <= acc;
        out_cycle <= cyc;
        acc       <= step_ext;
        idle_cnt  <= '0;
      end else begin
        if (out_ready) begin
          out_valid <= 1'b0;
        end
        // Saturate rather than wrap so a lost count is visible via overflow.
        acc <= clamp ? ACC_MAX : sum[BATCH_WIDTH-1:0];
        if (clamp) begin
          overflow <= 1'b1;
        end
        if ((in_step != '0) || !acc_nonzero) begin
          idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT_V) begin
          idle_cnt <= idle_cnt + IDLE_ONE;
        end
      end
    end
  end
endmodule
